// File: rtl/core_pfm_port_pkg.sv
// Shared core<->pfmonitor record types and constants (the scmem.vh definitions).
package core_pfm_port_pkg;

  localparam int unsigned PFM_DECID_BITS = 9;
  localparam int unsigned PFM_ADDR_BITS  = 48;

  typedef struct packed {
    logic [PFM_DECID_BITS-1:0] decid;
    logic [PFM_ADDR_BITS-1:0]  pc;
    logic                      is_ld;
    logic                      is_st;
  } I_coretopfm_dec_type;

  typedef struct packed {
    logic [PFM_DECID_BITS-1:0] decid;
    logic [PFM_ADDR_BITS-1:0]  ea;
  } I_coretopfm_retire_type;

  typedef struct packed {
    logic [PFM_DECID_BITS-1:0] decid;
    logic [PFM_ADDR_BITS-1:0]  paddr;
  } I_pfmtocore_pred_type;

endpackage

// File: rtl/pfm_pred_fifo.sv
// Prediction FIFO between pfmonitor and the core prefetch port; no push-to-pop bypass.
module pfm_pred_fifo
  import core_pfm_port_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push_valid_i,
  input  I_pfmtocore_pred_type push_data_i,
  output logic                 full_o,
  output logic                 pop_valid_o,
  output I_pfmtocore_pred_type pop_data_o,
  input  logic                 pop_retry_i
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q;
  I_pfmtocore_pred_type mem_q [Depth];
  logic                 empty, push, pop;

  // Full depends only on the stored count, so a same-cycle pop never frees a slot.
  assign full_o      = (cnt_q == CntW'(Depth));
  assign empty       = (cnt_q == '0);
  assign push        = push_valid_i && !full_o;
  assign pop         = !empty && !pop_retry_i;
  assign pop_valid_o = !empty;
  assign pop_data_o  = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/core_pfm_port.sv
// Core-side port to the prefetch monitor: lossy decode/retire records plus prediction FIFO.
// Optional saturating drop counters are built when PFM_DROPCNT_EN is defined.
module core_pfm_port
  import core_pfm_port_pkg::*;
#(
  parameter int unsigned PRED_DEPTH = 4,
  parameter int unsigned DROPW      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dec_valid,
  input  logic [PFM_ADDR_BITS-1:0]     dec_pc,
  input  logic                         dec_is_ld,
  input  logic                         dec_is_st,
  output logic [PFM_DECID_BITS-1:0]    dec_id,
  input  logic                         ret_valid,
  input  logic [PFM_DECID_BITS-1:0]    ret_decid,
  input  logic [PFM_ADDR_BITS-1:0]     ret_ea,
  output I_coretopfm_dec_type          coretopfm_dec,
  output logic                         coretopfm_dec_valid,
  input  logic                         coretopfm_dec_retry,
  output I_coretopfm_retire_type       coretopfm_retire,
  output logic                         coretopfm_retire_valid,
  input  logic                         coretopfm_retire_retry,
  input  I_pfmtocore_pred_type         pfmtocore_pred,
  input  logic                         pfmtocore_pred_valid,
  output logic                         pfmtocore_pred_retry,
  output logic [PFM_ADDR_BITS-1:0]     pfreq_paddr,
  output logic                         pfreq_valid,
  input  logic                         pfreq_retry,
  output logic [DROPW-1:0]             dec_drops,
  output logic [DROPW-1:0]             ret_drops
);

  logic [PFM_DECID_BITS-1:0] decid_q, decid_d;
  I_coretopfm_dec_type       dec_rec_q;
  I_coretopfm_retire_type    ret_rec_q;
  logic                      dec_vld_q, ret_vld_q;
  logic                      dec_take, ret_take;
  I_pfmtocore_pred_type      pred_head;
  logic                      unused_pred_decid;

  // The core is never stalled: an event is taken only if the register is free or draining.
  assign dec_take = dec_valid && (!dec_vld_q || !coretopfm_dec_retry);
  assign ret_take = ret_valid && (!ret_vld_q || !coretopfm_retire_retry);
  assign decid_d  = dec_valid ? decid_q + 1'b1 : decid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      decid_q   <= '0;
      dec_vld_q <= 1'b0;
      ret_vld_q <= 1'b0;
      dec_rec_q <= '0;
      ret_rec_q <= '0;
    end else begin
      decid_q <= decid_d;
      if (dec_take) begin
        dec_vld_q <= 1'b1;
        dec_rec_q <= '{decid: decid_q, pc: dec_pc, is_ld: dec_is_ld, is_st: dec_is_st};
      end else if (!coretopfm_dec_retry) begin
        dec_vld_q <= 1'b0;
      end
      if (ret_take) begin
        ret_vld_q <= 1'b1;
        ret_rec_q <= '{decid: ret_decid, ea: ret_ea};
      end else if (!coretopfm_retire_retry) begin
        ret_vld_q <= 1'b0;
      end
    end
  end

  assign dec_id                 = decid_q;
  assign coretopfm_dec          = dec_rec_q;
  assign coretopfm_dec_valid    = dec_vld_q;
  assign coretopfm_retire       = ret_rec_q;
  assign coretopfm_retire_valid = ret_vld_q;

`ifdef PFM_DROPCNT_EN
  logic [DROPW-1:0] dec_drops_q, ret_drops_q;
  logic             dec_drop, ret_drop;

  assign dec_drop = dec_valid && dec_vld_q && coretopfm_dec_retry;
  assign ret_drop = ret_valid && ret_vld_q && coretopfm_retire_retry;

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_drops_q <= '0;
      ret_drops_q <= '0;
    end else begin
      if (dec_drop && !(&dec_drops_q)) dec_drops_q <= dec_drops_q + 1'b1;
      if (ret_drop && !(&ret_drops_q)) ret_drops_q <= ret_drops_q + 1'b1;
    end
  end

  assign dec_drops = dec_drops_q;
  assign ret_drops = ret_drops_q;
`else
  assign dec_drops = '0;
  assign ret_drops = '0;
`endif

  pfm_pred_fifo #(
    .Depth (PRED_DEPTH)
  ) u_pred_fifo (
    .clk_i        (clk),
    .reset_i      (reset),
    .push_valid_i (pfmtocore_pred_valid),
    .push_data_i  (pfmtocore_pred),
    .full_o       (pfmtocore_pred_retry),
    .pop_valid_o  (pfreq_valid),
    .pop_data_o   (pred_head),
    .pop_retry_i  (pfreq_retry)
  );

  assign pfreq_paddr       = pred_head.paddr;
  assign unused_pred_decid = ^pred_head.decid;

endmodule

// File: tb/tb_core_pfm_port.sv
// Randomised scoreboard bench for core_pfm_port; drop-counter expectations follow PFM_DROPCNT_EN.
module tb_core_pfm_port;
  import core_pfm_port_pkg::*;

  localparam int unsigned Depth   = 4;
  localparam int unsigned DropW   = 16;
  localparam int unsigned MaxDrop = 65535;
`ifdef PFM_DROPCNT_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dec_valid = 1'b0, dec_is_ld = 1'b0, dec_is_st = 1'b0;
  logic [47:0] dec_pc = '0, ret_ea = '0, pfreq_paddr;
  logic [8:0] dec_id, ret_decid = '0;
  logic ret_valid = 1'b0;
  I_coretopfm_dec_type coretopfm_dec;
  I_coretopfm_retire_type coretopfm_retire;
  I_pfmtocore_pred_type pfmtocore_pred = '0;
  logic coretopfm_dec_valid, coretopfm_retire_valid, pfmtocore_pred_retry, pfreq_valid;
  logic coretopfm_dec_retry = 1'b0, coretopfm_retire_retry = 1'b0;
  logic pfmtocore_pred_valid = 1'b0, pfreq_retry = 1'b0;
  logic [DropW-1:0] dec_drops, ret_drops;

  always #5 clk = ~clk;

  core_pfm_port #(
    .PRED_DEPTH (Depth),
    .DROPW      (DropW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .dec_valid              (dec_valid),
    .dec_pc                 (dec_pc),
    .dec_is_ld              (dec_is_ld),
    .dec_is_st              (dec_is_st),
    .dec_id                 (dec_id),
    .ret_valid              (ret_valid),
    .ret_decid              (ret_decid),
    .ret_ea                 (ret_ea),
    .coretopfm_dec          (coretopfm_dec),
    .coretopfm_dec_valid    (coretopfm_dec_valid),
    .coretopfm_dec_retry    (coretopfm_dec_retry),
    .coretopfm_retire       (coretopfm_retire),
    .coretopfm_retire_valid (coretopfm_retire_valid),
    .coretopfm_retire_retry (coretopfm_retire_retry),
    .pfmtocore_pred         (pfmtocore_pred),
    .pfmtocore_pred_valid   (pfmtocore_pred_valid),
    .pfmtocore_pred_retry   (pfmtocore_pred_retry),
    .pfreq_paddr            (pfreq_paddr),
    .pfreq_valid            (pfreq_valid),
    .pfreq_retry            (pfreq_retry),
    .dec_drops              (dec_drops),
    .ret_drops              (ret_drops)
  );

  // Staged stimulus for the next cycle, applied on the falling edge.
  bit n_reset, n_dv, n_ld, n_st, n_dret, n_rv, n_rret, n_pv, n_pfret;
  logic [47:0] n_dpc, n_rea, n_paddr;
  logic [8:0] n_rdecid, n_pdecid;

  // Reference model state: occupancy of each stage plus expected-record queues.
  int unsigned m_id, m_pcnt, m_ddrops, m_rdrops;
  bit m_dheld, m_rheld, m_pv_pending, m_was_reset;
  I_coretopfm_dec_type    dq[$];
  I_coretopfm_retire_type rq[$];
  logic [47:0]            pq[$];

  // Per-cycle expectations handed from driver to monitor.
  bit s_skip = 1'b1, s_post_rst;
  logic [8:0] s_id;
  bit s_dvld, s_rvld, s_pfvld, s_pretry;
  logic [DropW-1:0] s_ddrops, s_rdrops;

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit dacc, ddrop, racc, rdrop, ppush, ppop;
    @(negedge clk);
    reset = n_reset;
    dec_valid = n_dv; dec_pc = n_dpc; dec_is_ld = n_ld; dec_is_st = n_st;
    coretopfm_dec_retry = n_dret;
    ret_valid = n_rv; ret_decid = n_rdecid; ret_ea = n_rea;
    coretopfm_retire_retry = n_rret;
    pfmtocore_pred_valid = n_pv;
    pfmtocore_pred = '{decid: n_pdecid, paddr: n_paddr};
    pfreq_retry = n_pfret;
    if (n_reset) begin
      s_skip = 1'b1;
      m_id = 0; m_pcnt = 0; m_ddrops = 0; m_rdrops = 0;
      m_dheld = 1'b0; m_rheld = 1'b0; m_pv_pending = 1'b0; m_was_reset = 1'b1;
      dq.delete(); rq.delete(); pq.delete();
      return;
    end
    s_skip = 1'b0;
    s_post_rst = m_was_reset;
    m_was_reset = 1'b0;
    s_id = m_id[8:0];
    s_dvld = m_dheld; s_rvld = m_rheld;
    s_pfvld = (m_pcnt != 0); s_pretry = (m_pcnt == Depth);
    s_ddrops = m_ddrops[DropW-1:0]; s_rdrops = m_rdrops[DropW-1:0];

    dacc  = n_dv && (!m_dheld || !n_dret);
    ddrop = n_dv && !dacc;
    if (dacc) dq.push_back('{decid: m_id[8:0], pc: n_dpc, is_ld: n_ld, is_st: n_st});
    if (n_dv) m_id = (m_id + 1) % 512;
    m_dheld = dacc || (m_dheld && n_dret);
    if (DropEn && ddrop && m_ddrops < MaxDrop) m_ddrops++;

    racc  = n_rv && (!m_rheld || !n_rret);
    rdrop = n_rv && !racc;
    if (racc) rq.push_back('{decid: n_rdecid, ea: n_rea});
    m_rheld = racc || (m_rheld && n_rret);
    if (DropEn && rdrop && m_rdrops < MaxDrop) m_rdrops++;

    ppush = n_pv && (m_pcnt != Depth);
    ppop  = (m_pcnt != 0) && !n_pfret;
    if (ppush) pq.push_back(n_paddr);
    m_pcnt = m_pcnt + 32'(ppush) - 32'(ppop);
    m_pv_pending = n_pv && !ppush;
  endtask

  task automatic idle();
    n_reset = 0; n_dv = 0; n_rv = 0; n_pv = 0;
    n_dret = 0; n_rret = 0; n_pfret = 0;
  endtask

  task automatic rand_dec();
    n_dv = 1'b1; n_dpc = {16'($urandom), $urandom};
    n_ld = 1'($urandom); n_st = 1'($urandom);
  endtask

  task automatic rand_ret();
    n_rv = 1'b1; n_rdecid = 9'($urandom); n_rea = {16'($urandom), $urandom};
  endtask

  // Monitor: compares registered outputs and retires expected records on each transfer.
  initial begin
    I_coretopfm_dec_type    ed;
    I_coretopfm_retire_type er;
    logic [47:0]            ep;
    forever begin
      @(negedge clk);
      #2;
      if (!s_skip) begin
        chk("dec_id", 64'(dec_id), 64'(s_id));
        chk("dec_valid", 64'(coretopfm_dec_valid), 64'(s_dvld));
        chk("ret_valid", 64'(coretopfm_retire_valid), 64'(s_rvld));
        chk("pfreq_valid", 64'(pfreq_valid), 64'(s_pfvld));
        chk("pred_retry", 64'(pfmtocore_pred_retry), 64'(s_pretry));
        chk("dec_drops", 64'(dec_drops), 64'(s_ddrops));
        chk("ret_drops", 64'(ret_drops), 64'(s_rdrops));
        if (s_post_rst) begin
          chk("dec_rec_rst", 64'(coretopfm_dec), 64'd0);
          chk("ret_rec_rst", 64'(coretopfm_retire), 64'd0);
          chk("paddr_rst", 64'(pfreq_paddr), 64'd0);
        end
        if (coretopfm_dec_valid && !coretopfm_dec_retry) begin
          if (dq.size() == 0) chk("dec_unexpected", 64'(coretopfm_dec), 64'd0);
          else begin ed = dq.pop_front(); chk("dec_rec", 64'(coretopfm_dec), 64'(ed)); end
        end
        if (coretopfm_retire_valid && !coretopfm_retire_retry) begin
          if (rq.size() == 0) chk("ret_unexpected", 64'(coretopfm_retire), 64'd0);
          else begin er = rq.pop_front(); chk("ret_rec", 64'(coretopfm_retire), 64'(er)); end
        end
        if (pfreq_valid && !pfreq_retry) begin
          if (pq.size() == 0) chk("pfreq_unexpected", 64'(pfreq_paddr), 64'd0);
          else begin ep = pq.pop_front(); chk("pfreq_paddr", 64'(pfreq_paddr), 64'(ep)); end
        end
      end
    end
  end

  initial begin
    n_dpc = '0; n_rea = '0; n_paddr = '0; n_rdecid = '0; n_pdecid = '0;
    n_ld = 0; n_st = 0;
    idle(); n_reset = 1; step(); step();
    idle(); step();

    // Three back-to-back decodes, no back-pressure.
    for (int i = 0; i < 3; i++) begin idle(); rand_dec(); step(); end
    idle(); step(); step();

    // Fill decode/retire registers, then drop two events each while retried.
    idle(); n_dret = 1; n_rret = 1; rand_dec(); rand_ret(); step();
    for (int i = 0; i < 2; i++) begin
      idle(); n_dret = 1; n_rret = 1; rand_dec(); rand_ret(); step();
    end
    idle(); n_dret = 1; n_rret = 1; step();
    idle(); rand_dec(); rand_ret(); step();
    idle(); step(); step();

    // Run the decode id through its wrap.
    for (int i = 0; i < 520; i++) begin idle(); rand_dec(); step(); end
    idle(); step(); step();

    // Fill the prediction FIFO under pfreq back-pressure, then release one pop.
    for (int i = 0; i < Depth; i++) begin
      idle(); n_pfret = 1; n_pv = 1;
      n_paddr = {16'($urandom), $urandom}; n_pdecid = 9'($urandom); step();
    end
    idle(); n_pfret = 1; step();
    idle(); step();
    idle(); n_pfret = 1; step();
    idle(); step(); step(); step(); step(); step();

    // Saturate both drop counters.
    idle(); n_dret = 1; n_rret = 1; rand_dec(); rand_ret(); step();
    for (int i = 0; i < 65540; i++) begin
      idle(); n_dret = 1; n_rret = 1; n_dv = 1; n_rv = 1; step();
    end
    idle(); step(); step();

    // Random traffic across all three channels.
    for (int i = 0; i < 3000; i++) begin
      idle();
      if ($urandom_range(0, 2) != 0) rand_dec();
      if ($urandom_range(0, 2) != 0) rand_ret();
      n_dret = ($urandom_range(0, 3) == 0);
      n_rret = ($urandom_range(0, 3) == 0);
      n_pfret = ($urandom_range(0, 2) == 0);
      if (m_pv_pending) n_pv = 1;
      else if ($urandom_range(0, 1) != 0) begin
        n_pv = 1; n_paddr = {16'($urandom), $urandom}; n_pdecid = 9'($urandom);
      end
      step();
    end
    idle(); step(); step(); step(); step(); step(); step();

    // Reset with a full FIFO and both record registers occupied.
    for (int i = 0; i < Depth; i++) begin
      idle(); n_pfret = 1; n_dret = 1; n_rret = 1; n_pv = 1; rand_dec(); rand_ret();
      n_paddr = {16'($urandom), $urandom}; step();
    end
    idle(); n_pfret = 1; n_dret = 1; n_rret = 1; step();
    idle(); n_reset = 1; n_pfret = 1; n_dret = 1; n_rret = 1; step();
    idle(); step(); step();
    idle(); rand_dec(); step();
    idle(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/core_pfm_port.md
CORE_PFM_PORT -- requirements
Module: core_pfm_port

Interface
REQ-001 SHALL have parameter PRED_DEPTH, default 4, prediction FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter DROPW, default 16, drop-counter width.
REQ-003 SHALL have ports, one per line:
- clk  in  1  the single clock
- reset  in  1  synchronous, active-high reset
- dec_valid  in  1  core decoded one instruction this cycle
- dec_pc  in  48  PC of that instruction
- dec_is_ld  in  1  load flag
- dec_is_st  in  1  store flag
- dec_id  out  9  decode id assigned to the current dec_valid event
- ret_valid  in  1  core retired one instruction
- ret_decid  in  9  decode id of the retired instruction
- ret_ea  in  48  effective address (0 if not a memory op)
- coretopfm_dec  out  I_coretopfm_dec_type  decode record to pfmonitor
- coretopfm_dec_valid  out  1  record valid
- coretopfm_dec_retry  in  1  pfmonitor back-pressure
- coretopfm_retire  out  I_coretopfm_retire_type  retire record to pfmonitor
- coretopfm_retire_valid  out  1  record valid
- coretopfm_retire_retry  in  1  pfmonitor back-pressure
- pfmtocore_pred  in  I_pfmtocore_pred_type  prefetch prediction
- pfmtocore_pred_valid  in  1  prediction valid
- pfmtocore_pred_retry  out  1  back-pressure to pfmonitor
- pfreq_paddr  out  48  prefetch address to core memory pipe
- pfreq_valid  out  1  prefetch request valid
- pfreq_retry  in  1  core back-pressure
- dec_drops  out  DROPW  dropped decode records
- ret_drops  out  DROPW  dropped retire records

Function
REQ-004 SHALL treat a transfer as valid && !retry; a sender SHALL hold valid and data stable until the transfer.
REQ-005 SHALL keep a 9-bit decode-id counter; dec_id equals the counter; it SHALL increment by 1 on every dec_valid, dropped or not, and wrap from 511 to 0.
REQ-006 SHALL register the decode record {decid, pc, is_ld, is_st} into a one-entry output register when dec_valid is high and the register is empty or is transferring this cycle; coretopfm_dec_valid SHALL rise the next cycle (1-cycle latency).
REQ-007 SHALL drop a dec_valid event when the decode register is full and coretopfm_dec_retry is high; the core is never stalled.
REQ-008 SHALL handle the retire path ({decid, ea}) identically to REQ-006/007 using its own register, retry and drop condition.
REQ-009 SHALL push pfmtocore_pred into a PRED_DEPTH FIFO on transfer; pfmtocore_pred_retry SHALL equal FIFO full, computed from the current count only.
REQ-010 SHALL drive pfreq_valid = !empty and pfreq_paddr = head.paddr, and pop on pfreq transfer; a push to an empty FIFO SHALL be visible the next cycle (no bypass).
REQ-011 SHALL, on simultaneous push and pop, keep the count unchanged; at full, retry remains high that cycle regardless of a pop.
REQ-012 SHALL wrap FIFO read and write pointers modulo PRED_DEPTH.

Reset
REQ-013 SHALL, on reset, clear the decode-id counter, both output valids, FIFO pointers and count, and both drop counters; all outputs read 0 the cycle after reset; reset mid-transfer discards held records and FIFO contents.

Configuration
REQ-014 SHALL, with PFM_DROPCNT_EN defined, increment dec_drops/ret_drops on each drop and saturate at all-ones; without it, these outputs SHALL be tied to 0 and no counter flops exist.

Structure
REQ-015 SHALL take I_coretopfm_dec_type, I_coretopfm_retire_type, I_pfmtocore_pred_type (decid 9, paddr 48) and a PFM_DECID_BITS=9 constant from the shared scmem.vh package.
REQ-016 SHALL implement the prediction FIFO as one sub-module, pfm_pred_fifo.

Verification
REQ-017 Bench SHALL cover:
- 3 dec_valid events, retry=0 -> records decid 0,1,2 appear one cycle later, dec_drops=0.
- Decode register full, coretopfm_dec_retry=1, 2 dec_valid events -> held record unchanged, dec_drops=2, next accepted record has decid 3.
- 512 dec_valid events -> decid sequence wraps 511 -> 0.
- 4 preds pushed, pfreq_retry=1 -> pfmtocore_pred_retry=1; one pop -> retry=0 the next cycle; addresses popped in FIFO order.
- Drop counter forced to 0xFFFF with an extra drop -> stays 0xFFFF (macro on); with the macro off -> reads 0.
- Reset asserted with full FIFO and both output valids high -> all valids, counts and drops read 0 the next cycle.
